// File: rtl/data_mem_stack_if.sv
// data_mem_stack_if: shared data port plus hardware call-stack port of data_mem_stack.
// master = datapath side (drives requests), slave = memory side.
interface data_mem_stack_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 9
);
   // shared data port
   logic [AW-1:0]    address;
   logic             mem_write;
   logic [WIDTH-1:0] write_data;
   logic             acc_write;
   logic [WIDTH-1:0] acc_data;
   logic             crypto_write;
   logic [WIDTH-1:0] crypto_data;
   logic [WIDTH-1:0] read_data;

   // call stack port
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             pop;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic [AW-1:0]    sp;
   logic             stack_empty;
   logic             stack_full;

   // status
   logic             collision;
   logic             overflow;
   logic             underflow;
   logic             err_clr;

   modport master (
      output address, mem_write, write_data, acc_write, acc_data,
             crypto_write, crypto_data, push, push_data, pop, err_clr,
      input  read_data, pop_data, pop_valid, sp, stack_empty, stack_full,
             collision, overflow, underflow
   );

   modport slave (
      input  address, mem_write, write_data, acc_write, acc_data,
             crypto_write, crypto_data, push, push_data, pop, err_clr,
      output read_data, pop_data, pop_valid, sp, stack_empty, stack_full,
             collision, overflow, underflow
   );
endinterface

// File: rtl/data_mem_stack.sv
// data_mem_stack: shared-port data memory (crypto > acc > X/Y write priority)
// with a downward-growing hardware call stack living in the same array.
// Optional macro DATA_MEM_RET_INC_EN: popped values are returned incremented
// by one (return address past the CALL); otherwise the raw stored value.
module data_mem_stack #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 400,
   parameter int unsigned AW          = 9,
   parameter int unsigned STACK_BASE  = 399,
   parameter int unsigned STACK_DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   data_mem_stack_if.slave  bus
);

   localparam int unsigned   CW      = $clog2(STACK_DEPTH + 1);
   localparam int unsigned   AW1     = AW + 1;
   localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);
   localparam logic [AW-1:0] BASE_A  = AW'(STACK_BASE);
   localparam logic [CW-1:0] FULL_C  = CW'(STACK_DEPTH);

   // storage (not reset)
   logic [WIDTH-1:0] r_mem [DEPTH];

   // stack and status registers
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_pop_data;
   logic             r_pop_valid;
   logic             r_collision;
   logic             r_overflow;
   logic             r_underflow;

   // derived stack state
   logic             w_empty;
   logic             w_full;
   logic [AW-1:0]    w_push_addr;
   logic [AW-1:0]    w_top_addr;
   logic [WIDTH-1:0] w_pop_val;

   // stack decisions
   logic             w_stack_we;
   logic [AW-1:0]    w_stack_addr;
   logic             w_pop_fire;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_ovf_evt;
   logic             w_unf_evt;

   // shared-port decisions
   logic             w_addr_ok;
   logic             w_sh_any;
   logic             w_sh_multi;
   logic [WIDTH-1:0] w_sh_data;
   logic             w_sh_conflict;
   logic             w_sh_we;
   logic             w_coll_nxt;

   assign w_empty     = (r_cnt == '0);
   assign w_full      = (r_cnt == FULL_C);
   assign w_push_addr = BASE_A - AW'(r_cnt);
   assign w_top_addr  = BASE_A - AW'(r_cnt) + AW'(1);
   assign w_addr_ok   = ({1'b0, bus.address} < DEPTH_W);

`ifdef DATA_MEM_RET_INC_EN
   assign w_pop_val = r_mem[w_top_addr] + WIDTH'(1);
`else
   assign w_pop_val = r_mem[w_top_addr];
`endif

   // stack operation decode: push, pop, swap (push+pop) and error events
   always_comb begin
      w_stack_we   = 1'b0;
      w_stack_addr = w_push_addr;
      w_pop_fire   = 1'b0;
      w_cnt_nxt    = r_cnt;
      w_ovf_evt    = 1'b0;
      w_unf_evt    = 1'b0;
      if (bus.push && bus.pop && !w_empty) begin
         // swap: old top leaves via pop_data, new value overwrites it in place
         w_stack_we   = 1'b1;
         w_stack_addr = w_top_addr;
         w_pop_fire   = 1'b1;
      end else if (bus.push) begin
         // a pop paired with a push on an empty stack degrades to push only
         w_unf_evt = bus.pop;
         if (w_full) begin
            w_ovf_evt = 1'b1;
         end else begin
            w_stack_we = 1'b1;
            w_cnt_nxt  = r_cnt + CW'(1);
         end
      end else if (bus.pop) begin
         if (w_empty) begin
            w_unf_evt = 1'b1;
         end else begin
            w_pop_fire = 1'b1;
            w_cnt_nxt  = r_cnt - CW'(1);
         end
      end
   end

   // shared-port priority select and conflict detection against the stack
   always_comb begin
      w_sh_any      = bus.crypto_write | bus.acc_write | bus.mem_write;
      w_sh_multi    = (bus.crypto_write & bus.acc_write) |
                      (bus.crypto_write & bus.mem_write) |
                      (bus.acc_write    & bus.mem_write);
      w_sh_data     = bus.write_data;
      if (bus.crypto_write) begin
         w_sh_data = bus.crypto_data;
      end else if (bus.acc_write) begin
         w_sh_data = bus.acc_data;
      end
      w_sh_conflict = w_sh_any & w_stack_we & (bus.address == w_stack_addr);
      w_sh_we       = w_sh_any & w_addr_ok & ~w_sh_conflict;
      w_coll_nxt    = w_sh_multi | w_sh_conflict;
   end

   // memory array writes; nothing is written in a reset cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_sh_we) begin
            r_mem[bus.address] <= w_sh_data;
         end
         if (w_stack_we) begin
            r_mem[w_stack_addr] <= bus.push_data;
         end
      end
   end

   // stack counter, pop path and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_collision <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_pop_valid <= w_pop_fire;
         r_collision <= w_coll_nxt;
         if (w_pop_fire) begin
            r_pop_data <= w_pop_val;
         end
         // a new error event in the clearing cycle keeps the flag set
         r_overflow  <= (r_overflow  & ~bus.err_clr) | w_ovf_evt;
         r_underflow <= (r_underflow & ~bus.err_clr) | w_unf_evt;
      end
   end

   assign bus.read_data   = w_addr_ok ? r_mem[bus.address] : '0;
   assign bus.pop_data    = r_pop_data;
   assign bus.pop_valid   = r_pop_valid;
   assign bus.sp          = w_top_addr;
   assign bus.stack_empty = w_empty;
   assign bus.stack_full  = w_full;
   assign bus.collision   = r_collision;
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;

endmodule
